stack_cpu_core: RTL

//  Next-generation stack CPU: parametrised data width, stack depth and immediate width.

---
 rtl/stack_cpu_core.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/stack_cpu_core.sv
// Stack CPU core: a FETCH/EXEC/WB machine over an internal operand stack, fetching
// from a combinational program memory addressed by pc. Faults and HALT are sticky.
module stack_cpu_core #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter int unsigned INSTR_WIDTH  = 16,
    parameter int unsigned PC_WIDTH     = 8,
    parameter bit          SSTEP_ENABLE = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [INSTR_WIDTH-1:0]           instruction,
    input  logic                             single_step,
    output logic [PC_WIDTH-1:0]              pc,
    output logic [DATA_WIDTH-1:0]            result,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             retire,
    output logic                             error,
    output logic [1:0]                       error_code,
    output logic                             halt
);

    localparam int unsigned SW    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW    = $clog2(STACK_DEPTH);
    localparam int unsigned IMM_W = INSTR_WIDTH - 6;

    localparam logic [4:0] OpPush = 5'b00000, OpAdd  = 5'b00001, OpSub  = 5'b00010;
    localparam logic [4:0] OpMul  = 5'b00011, OpDiv  = 5'b00100, OpMod  = 5'b00101;
    localparam logic [4:0] OpAnd  = 5'b00110, OpOr   = 5'b00111, OpInv  = 5'b01000;
    localparam logic [4:0] OpXor  = 5'b01001, OpDup  = 5'b01010, OpDrop = 5'b01011;
    localparam logic [4:0] OpSwap = 5'b01100, OpJz   = 5'b01101, OpJmp  = 5'b01110;
    localparam logic [4:0] OpHalt = 5'b11111;

    localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StFetch, StExec, StWb, StError, StHalted} state_e;

    state_e                  state_q;
    logic [4:0]              op_q;
    logic [IMM_W-1:0]        imm_q;
    logic [PC_WIDTH-1:0]     pc_q, wb_pc_q;
    logic [SW-1:0]           sp_q, wb_sp_q;
    logic [DATA_WIDTH-1:0]   stk_q [STACK_DEPTH];
    logic [DATA_WIDTH-1:0]   wb_val_q;
    logic [IW-1:0]           wb_idx_q;
    logic                    wb_wr_q, wb_swap_q, wb_halt_q;
    logic                    retire_q, error_q, halt_q, ss_prev_q;
    logic [1:0]              err_code_q;

    // The reserved zero bit between opcode and immediate carries no meaning.
    logic unused_rsvd;
    assign unused_rsvd = instruction[IMM_W];

    logic signed [IMM_W-1:0]      imm_s;
    logic [DATA_WIDTH-1:0]        imm_ext, t_val, n_val;
    logic [IW-1:0]                idx_t, idx_n, idx_p;
    logic signed [DATA_WIDTH-1:0] t_s, n_s, quot, rem;

    assign imm_s   = imm_q;
    assign imm_ext = DATA_WIDTH'(imm_s);
    assign idx_t   = IW'(sp_q - SW'(1));
    assign idx_n   = IW'(sp_q - SW'(2));
    assign idx_p   = IW'(sp_q);
    assign t_val   = stk_q[idx_t];
    assign n_val   = stk_q[idx_n];

    // Signed divide; MIN / -1 wraps back to MIN and a zero divisor is faulted elsewhere.
    always_comb begin
        t_s  = t_val;
        n_s  = n_val;
        quot = '0;
        rem  = '0;
        if (t_val == '0) begin
            quot = '0;
        end else if (n_val == MinVal && t_val == '1) begin
            quot = n_s;
        end else begin
            quot = n_s / t_s;
            rem  = n_s % t_s;
        end
    end

    logic                  legal, grows, is_div, fault;
    logic                  ex_wr, ex_swap, ex_halt;
    logic [SW-1:0]         need, ex_sp;
    logic [1:0]            fault_code;
    logic [IW-1:0]         ex_idx;
    logic [DATA_WIDTH-1:0] ex_val;
    logic [PC_WIDTH-1:0]   ex_pc;

    always_comb begin
        legal   = 1'b1;
        grows   = 1'b0;
        is_div  = 1'b0;
        need    = '0;
        ex_wr   = 1'b0;
        ex_swap = 1'b0;
        ex_halt = 1'b0;
        ex_idx  = idx_n;
        ex_val  = '0;
        ex_sp   = sp_q - SW'(1);
        ex_pc   = pc_q + PC_WIDTH'(1);
        case (op_q)
            OpPush: begin
                grows = 1'b1; ex_wr = 1'b1; ex_idx = idx_p; ex_val = imm_ext;
                ex_sp = sp_q + SW'(1);
            end
            OpAdd: begin need = SW'(2); ex_wr = 1'b1; ex_val = n_val + t_val; end
            OpSub: begin need = SW'(2); ex_wr = 1'b1; ex_val = n_val - t_val; end
            OpMul: begin need = SW'(2); ex_wr = 1'b1; ex_val = n_val * t_val; end
            OpDiv: begin need = SW'(2); ex_wr = 1'b1; is_div = 1'b1; ex_val = quot; end
            OpMod: begin need = SW'(2); ex_wr = 1'b1; is_div = 1'b1; ex_val = rem; end
            OpAnd: begin need = SW'(2); ex_wr = 1'b1; ex_val = n_val & t_val; end
            OpOr:  begin need = SW'(2); ex_wr = 1'b1; ex_val = n_val | t_val; end
            OpXor: begin need = SW'(2); ex_wr = 1'b1; ex_val = n_val ^ t_val; end
            OpInv: begin
                need = SW'(1); ex_wr = 1'b1; ex_idx = idx_t; ex_val = ~t_val; ex_sp = sp_q;
            end
            OpDup: begin
                need = SW'(1); grows = 1'b1; ex_wr = 1'b1; ex_idx = idx_p; ex_val = t_val;
                ex_sp = sp_q + SW'(1);
            end
            OpDrop: need = SW'(1);
            OpSwap: begin need = SW'(2); ex_swap = 1'b1; ex_sp = sp_q; end
            OpJz: begin
                need = SW'(1);
                if (t_val == '0) ex_pc = imm_q[PC_WIDTH-1:0];
            end
            OpJmp: begin ex_sp = sp_q; ex_pc = imm_q[PC_WIDTH-1:0]; end
            OpHalt: begin ex_sp = sp_q; ex_pc = pc_q; ex_halt = 1'b1; end
            default: legal = 1'b0;
        endcase

        fault      = 1'b1;
        fault_code = 2'b00;
        if (!legal) begin
            fault_code = 2'b00;
        end else if (sp_q < need) begin
            fault_code = 2'b01;
        end else if (grows && sp_q == SW'(STACK_DEPTH)) begin
            fault_code = 2'b10;
        end else if (is_div && t_val == '0) begin
            fault_code = 2'b11;
        end else begin
            fault = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StFetch;
            op_q       <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            sp_q       <= '0;
            wb_pc_q    <= '0;
            wb_sp_q    <= '0;
            wb_val_q   <= '0;
            wb_idx_q   <= '0;
            wb_wr_q    <= 1'b0;
            wb_swap_q  <= 1'b0;
            wb_halt_q  <= 1'b0;
            retire_q   <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
            halt_q     <= 1'b0;
            ss_prev_q  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            ss_prev_q <= single_step;
            retire_q  <= 1'b0;
            case (state_q)
                StFetch: begin
                    if (!SSTEP_ENABLE || (single_step && !ss_prev_q)) begin
                        op_q    <= instruction[INSTR_WIDTH-1 -: 5];
                        imm_q   <= instruction[IMM_W-1:0];
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (fault) begin
                        error_q    <= 1'b1;
                        err_code_q <= fault_code;
                        state_q    <= StError;
                    end else begin
                        wb_wr_q   <= ex_wr;
                        wb_swap_q <= ex_swap;
                        wb_halt_q <= ex_halt;
                        wb_idx_q  <= ex_idx;
                        wb_val_q  <= ex_val;
                        wb_sp_q   <= ex_sp;
                        wb_pc_q   <= ex_pc;
                        retire_q  <= 1'b1;
                        state_q   <= StWb;
                    end
                end
                StWb: begin
                    // sp is still the pre-instruction value here, so T/N indices remain valid.
                    if (wb_swap_q) begin
                        stk_q[idx_t] <= n_val;
                        stk_q[idx_n] <= t_val;
                    end else if (wb_wr_q) begin
                        stk_q[wb_idx_q] <= wb_val_q;
                    end
                    sp_q <= wb_sp_q;
                    pc_q <= wb_pc_q;
                    if (wb_halt_q) begin
                        halt_q  <= 1'b1;
                        state_q <= StHalted;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc         = pc_q;
    assign depth      = sp_q;
    assign result     = (sp_q == '0) ? '0 : t_val;
    assign retire     = retire_q;
    assign error      = error_q;
    assign error_code = err_code_q;
    assign halt       = halt_q;

endmodule
